id_ex_stage: RTL

//  ID/EX pipeline register and EX operand path of the 5-stage core; drives alu opcode/operands.

---
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, EX operand selection and RAW hazard detection.
// Macro ID_EX_FWD_EN: EX/MEM and MEM/WB forwarding with load-use stalls; undefined: stall on any RAW.
`ifndef ALU_ADDU
`define ALU_ADDU 4'd0
`endif

module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [3:0]         id_alu_opcode,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic               id_rs1_used,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic               id_rs2_used,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               id_x_sel_pc,
    input  logic               id_y_sel_imm,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_reg_we,
    input  logic               id_mem_read,
    input  logic               ex_hold,
    input  logic               flush,
    input  logic [RADDR_W-1:0] exmem_rd_addr,
    input  logic               exmem_reg_we,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [RADDR_W-1:0] memwb_rd_addr,
    input  logic               memwb_reg_we,
    input  logic [XLEN-1:0]    memwb_result,
    output logic               ex_valid,
    output logic [3:0]         ex_alu_opcode,
    output logic [XLEN-1:0]    alu_op_x,
    output logic [XLEN-1:0]    alu_op_y,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_we,
    output logic               ex_mem_read,
    output logic               hazard_stall
);

    typedef struct packed {
        logic               valid;
        logic [3:0]         alu_opcode;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic               x_sel_pc;
        logic               y_sel_imm;
        logic [RADDR_W-1:0] rd_addr;
        logic               reg_we;
        logic               mem_read;
    } ex_regs_t;

    ex_regs_t          ex_r;
    ex_regs_t          id_fields_s;
    logic              raw_s;
    logic              hazard_stall_s;
    logic [XLEN-1:0]   src1_s;
    logic [XLEN-1:0]   src2_s;
    logic [XLEN-1:0]   alu_op_x_s;
    logic [XLEN-1:0]   alu_op_y_s;

    function automatic ex_regs_t bubble_f();
        ex_regs_t b;
        b            = '0;
        b.alu_opcode = `ALU_ADDU;
        return b;
    endfunction

    // A writer "hits" a source only when it writes a non-zero register equal to that source.
    function automatic logic writer_hit_f(input logic we, input logic [RADDR_W-1:0] rd,
                                          input logic [RADDR_W-1:0] rs);
        return we && (rd != {RADDR_W{1'b0}}) && (rd == rs);
    endfunction

    // Pack the decoded ID fields into the EX register image.
    always_comb begin
        id_fields_s            = bubble_f();
        id_fields_s.valid      = 1'b1;
        id_fields_s.alu_opcode = id_alu_opcode;
        id_fields_s.rs1_addr   = id_rs1_addr;
        id_fields_s.rs2_addr   = id_rs2_addr;
        id_fields_s.rs1_data   = id_rs1_data;
        id_fields_s.rs2_data   = id_rs2_data;
        id_fields_s.imm        = id_imm;
        id_fields_s.pc         = id_pc;
        id_fields_s.x_sel_pc   = id_x_sel_pc;
        id_fields_s.y_sel_imm  = id_y_sel_imm;
        id_fields_s.rd_addr    = id_rd_addr;
        id_fields_s.reg_we     = id_reg_we;
        id_fields_s.mem_read   = id_mem_read;
    end

    // RAW hazard detection; a downstream hold masks the stall since nothing moves anyway.
    always_comb begin
`ifdef ID_EX_FWD_EN
        raw_s = id_valid &&
                ((id_rs1_used && writer_hit_f(ex_r.valid && ex_r.mem_read, ex_r.rd_addr, id_rs1_addr)) ||
                 (id_rs2_used && writer_hit_f(ex_r.valid && ex_r.mem_read, ex_r.rd_addr, id_rs2_addr)));
`else
        raw_s = id_valid &&
                ((id_rs1_used && (writer_hit_f(ex_r.valid && ex_r.reg_we, ex_r.rd_addr, id_rs1_addr) ||
                                  writer_hit_f(exmem_reg_we, exmem_rd_addr, id_rs1_addr) ||
                                  writer_hit_f(memwb_reg_we, memwb_rd_addr, id_rs1_addr))) ||
                 (id_rs2_used && (writer_hit_f(ex_r.valid && ex_r.reg_we, ex_r.rd_addr, id_rs2_addr) ||
                                  writer_hit_f(exmem_reg_we, exmem_rd_addr, id_rs2_addr) ||
                                  writer_hit_f(memwb_reg_we, memwb_rd_addr, id_rs2_addr))));
`endif
        if (ex_hold) begin
            hazard_stall_s = 1'b0;
        end else begin
            hazard_stall_s = raw_s;
        end
    end

`ifdef ID_EX_FWD_EN
    // Operand sources: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        if (writer_hit_f(exmem_reg_we, exmem_rd_addr, ex_r.rs1_addr)) begin
            src1_s = exmem_result;
        end else if (writer_hit_f(memwb_reg_we, memwb_rd_addr, ex_r.rs1_addr)) begin
            src1_s = memwb_result;
        end else begin
            src1_s = ex_r.rs1_data;
        end
        if (writer_hit_f(exmem_reg_we, exmem_rd_addr, ex_r.rs2_addr)) begin
            src2_s = exmem_result;
        end else if (writer_hit_f(memwb_reg_we, memwb_rd_addr, ex_r.rs2_addr)) begin
            src2_s = memwb_result;
        end else begin
            src2_s = ex_r.rs2_data;
        end
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{exmem_result, memwb_result, ex_r.rs1_addr, ex_r.rs2_addr};

    // Without forwarding the stall guarantees the captured regfile data is current.
    always_comb begin
        src1_s = ex_r.rs1_data;
        src2_s = ex_r.rs2_data;
    end
`endif

    // ALU operand muxes; the decoder already ordered operands for shifts.
    always_comb begin
        if (ex_r.x_sel_pc) begin
            alu_op_x_s = ex_r.pc;
        end else begin
            alu_op_x_s = src1_s;
        end
        if (ex_r.y_sel_imm) begin
            alu_op_y_s = ex_r.imm;
        end else begin
            alu_op_y_s = src2_s;
        end
    end

    // EX register update: flush, then hold, then bubble on stall/empty ID, else capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r <= bubble_f();
        end else if (flush) begin
            ex_r <= bubble_f();
        end else if (ex_hold) begin
            ex_r <= ex_r;
        end else if (hazard_stall_s || !id_valid) begin
            ex_r <= bubble_f();
        end else begin
            ex_r <= id_fields_s;
        end
    end

    assign ex_valid      = ex_r.valid;
    assign ex_alu_opcode = ex_r.alu_opcode;
    assign ex_rd_addr    = ex_r.rd_addr;
    assign ex_reg_we     = ex_r.reg_we;
    assign ex_mem_read   = ex_r.mem_read;
    assign alu_op_x      = alu_op_x_s;
    assign alu_op_y      = alu_op_y_s;
    assign ex_store_data = src2_s;
    assign hazard_stall  = hazard_stall_s;

endmodule
